sc_config_sequencer: RTL
========================

// Module: sc_config_sequencer
// PURPOSE
//  Double-buffers the eight scanconverter timing/scaling config words (h/v_out_config[2], xy, misc, sl[2]).
//  Applies a committed set atomically at an output frame boundary (VSYNC_i falling edge).
//  Optionally mutes video for a few frames after an apply so the output never shows a torn or partially updated frame.
//  Sits between the CPU register bank and the scanconverter, in the PCLK_OUT_i domain.
// PARAMETERS
//  MUTE_FRAMES     2          frames mute_o stays high after an apply; 0 = never mute
//  TIMEOUT_CYCLES  8000000    max cycles ARMED waits for a vsync edge before forcing the apply
// PORTS
//  PCLK_OUT_i      in   1   output pixel clock; single clock domain
//  reset_n         in   1   asynchronous active-low reset
//  cfg_wr_i        in   1   staging write strobe
//  cfg_addr_i      in   3   word select: 0 h_out_config, 1 h_out_config2, 2 v_out_config, 3 v_out_config2,
//                           4 xy_out_config, 5 misc_config, 6 sl_config, 7 sl_config2
//  cfg_wdata_i     in   32  staging write data
//  cfg_commit_i    in   1   request apply of the staging set (1-cycle strobe)
//  VSYNC_i         in   1   scanconverter VSYNC_o, active low
//  h_out_config_o .. sl_config2_o   out  32 each (8 ports)   active config words to the scanconverter
//  cfg_busy_o      out  1   high in ARMED, or while a commit is deferred
//  cfg_applied_o   out  1   1-cycle pulse in the cycle the new active words first appear
//  cfg_err_o       out  1   1-cycle pulse: write rejected, or apply forced by timeout
//  mute_o          out  1   high = scanconverter must blank its RGB output
// BEHAVIOUR
//  - Reset: all staging and active words 0; state IDLE; all 1-bit outputs 0; counters 0; vs_prev=1.
//    Active words stay 0 until the first commit; the scanconverter output is undefined until then.
//  - Vsync edge: vs_edge = vs_prev & ~VSYNC_i; vs_prev is registered every cycle.
//  - FSM IDLE:
//    - cfg_wr_i writes staging[cfg_addr_i].
//    - cfg_commit_i -> ARMED; timeout counter cleared.
//    - Write and commit in the same cycle: the write is included in the applied set.
//  - FSM ARMED:
//    - cfg_wr_i is rejected: staging is unchanged and cfg_err_o pulses.
//    - cfg_commit_i is ignored.
//    - A commit's own cycle is never the apply cycle; a vs_edge coinciding with the commit is not used.
//    - vs_edge -> APPLY. Timeout counter == TIMEOUT_CYCLES-1 -> APPLY with cfg_err_o pulse.
//  - FSM APPLY (1 cycle):
//    - Copy all 8 staging words into the active outputs; cfg_applied_o=1.
//    - Next state: HOLD if MUTE_FRAMES>0, else IDLE.
//    - Latency: vs_edge at cycle N -> new active words and applied pulse at cycle N+1.
//  - FSM HOLD:
//    - mute_o=1; frame counter counts vs_edge. At count MUTE_FRAMES -> IDLE, and mute_o drops the same cycle.
//    - Writes are accepted into staging.
//    - A commit sets the deferred flag (cfg_busy_o=1). On HOLD exit with the flag set: flag cleared, go straight to ARMED.
//  - mute_o is also 1 in APPLY when MUTE_FRAMES>0 (registered; asserted in the apply cycle).
//  - Counters saturate and never wrap: timeout 24 bit, frame counter 4 bit (MUTE_FRAMES<=15).
//  - Reset mid-ARMED/HOLD discards the pending commit and clears the active words to 0.
// CONFIGURATION
//  SC_CFG_READBACK_EN defined:
//    - Adds port cfg_rdata_o (out, 32): registered, 1-cycle latency, returns the ACTIVE word at cfg_addr_i.
//    - Reset value 0.
//  SC_CFG_READBACK_EN undefined:
//    - Port is absent; no readback mux is built.
//    - All other behaviour is identical.
// TESTING
//  1 Write addr0=0x1234 and addr7=0xBEEF, commit; VSYNC_i falls 100 cycles later.
//    -> h_out_config_o=0x1234 and sl_config2_o=0xBEEF exactly 1 cycle after the edge; cfg_applied_o pulses once.
//  2 cfg_wr_i while ARMED (addr2=0xFFFF).
//    -> cfg_err_o pulse; after apply v_out_config_o keeps the pre-write staging value.
//  3 Commit with VSYNC_i held high; TIMEOUT_CYCLES=1000.
//    -> apply at cycle 1001 after commit, with cfg_err_o and cfg_applied_o both high.
//  4 MUTE_FRAMES=2: commit, then 3 vsync edges.
//    -> mute_o high from the apply cycle through the 3rd edge (the 2nd post-apply edge); low the cycle it is counted.
//  5 Commit during HOLD.
//    -> cfg_busy_o=1; ARMED on HOLD exit; the next vsync edge applies the new set.
//  6 reset_n low while ARMED -> all outputs 0 immediately; no applied pulse after release.
//    With SC_CFG_READBACK_EN: addr5 reads the active misc_config 1 cycle after the address is presented.

Source files
------------

// File: rtl/sc_config_sequencer.sv
// Double-buffered scanconverter config words, applied atomically on a VSYNC falling edge,
// with optional post-apply video mute. Optional readback port: define SC_CFG_READBACK_EN.
module sc_config_sequencer #(
    parameter int unsigned MUTE_FRAMES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8000000
) (
    input  logic        PCLK_OUT_i,
    input  logic        reset_n,
    input  logic        cfg_wr_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    input  logic        cfg_commit_i,
    input  logic        VSYNC_i,
    output logic [31:0] h_out_config_o,
    output logic [31:0] h_out_config2_o,
    output logic [31:0] v_out_config_o,
    output logic [31:0] v_out_config2_o,
    output logic [31:0] xy_out_config_o,
    output logic [31:0] misc_config_o,
    output logic [31:0] sl_config_o,
    output logic [31:0] sl_config2_o,
    output logic        cfg_busy_o,
    output logic        cfg_applied_o,
    output logic        cfg_err_o,
    output logic        mute_o
`ifdef SC_CFG_READBACK_EN
    ,
    output logic [31:0] cfg_rdata_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_APPLY,
        ST_HOLD
    } state_e;

    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  MUTE_CNT     = 4'(MUTE_FRAMES);
    localparam logic        MUTE_EN      = (MUTE_FRAMES > 0);

    state_e      state_q, state_d;
    logic [31:0] staging_q [8];
    logic [31:0] staging_d [8];
    logic [31:0] active_q  [8];
    logic [31:0] active_d  [8];
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic        vs_prev_q;
    logic        deferred_q, deferred_d;
    logic        applied_q, applied_d;
    logic        err_q, err_d;
    logic        mute_q, mute_d;
    logic        vs_edge;
    logic [3:0]  frame_cnt_nxt;

    assign vs_edge       = vs_prev_q & ~VSYNC_i;
    assign frame_cnt_nxt = (frame_cnt_q == 4'hF) ? 4'hF : frame_cnt_q + 4'd1;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        staging_d   = staging_q;
        active_d    = active_q;
        tmo_cnt_d   = tmo_cnt_q;
        frame_cnt_d = frame_cnt_q;
        deferred_d  = deferred_q;
        applied_d   = 1'b0;
        err_d       = 1'b0;
        mute_d      = mute_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_wr_i) staging_d[cfg_addr_i] = cfg_wdata_i;
                if (cfg_commit_i) begin
                    state_d   = ST_ARMED;
                    tmo_cnt_d = '0;
                end
            end
            ST_ARMED: begin
                if (cfg_wr_i) err_d = 1'b1;
                if (vs_edge || tmo_cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_APPLY;
                    active_d  = staging_q;
                    applied_d = 1'b1;
                    mute_d    = MUTE_EN;
                    if (!vs_edge) err_d = 1'b1;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 24'd1;
                end
            end
            ST_APPLY: begin
                if (cfg_wr_i) staging_d[cfg_addr_i] = cfg_wdata_i;
                frame_cnt_d = '0;
                if (MUTE_EN) begin
                    state_d    = ST_HOLD;
                    deferred_d = cfg_commit_i;
                end else if (cfg_commit_i) begin
                    state_d   = ST_ARMED;
                    tmo_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cfg_wr_i) staging_d[cfg_addr_i] = cfg_wdata_i;
                if (cfg_commit_i) deferred_d = 1'b1;
                if (vs_edge) begin
                    frame_cnt_d = frame_cnt_nxt;
                    // A commit seen while muted is carried straight into ARMED on exit.
                    if (frame_cnt_nxt == MUTE_CNT) begin
                        mute_d     = 1'b0;
                        deferred_d = 1'b0;
                        tmo_cnt_d  = '0;
                        state_d    = (deferred_q || cfg_commit_i) ? ST_ARMED : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: staging/active arrays are real config registers whose reset value is defined, so they are reset.
    always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < 8; i++) begin
                staging_q[i] <= '0;
                active_q[i]  <= '0;
            end
            tmo_cnt_q   <= '0;
            frame_cnt_q <= '0;
            vs_prev_q   <= 1'b1;
            deferred_q  <= 1'b0;
            applied_q   <= 1'b0;
            err_q       <= 1'b0;
            mute_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            staging_q   <= staging_d;
            active_q    <= active_d;
            tmo_cnt_q   <= tmo_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            vs_prev_q   <= VSYNC_i;
            deferred_q  <= deferred_d;
            applied_q   <= applied_d;
            err_q       <= err_d;
            mute_q      <= mute_d;
        end
    end

    assign h_out_config_o  = active_q[0];
    assign h_out_config2_o = active_q[1];
    assign v_out_config_o  = active_q[2];
    assign v_out_config2_o = active_q[3];
    assign xy_out_config_o = active_q[4];
    assign misc_config_o   = active_q[5];
    assign sl_config_o     = active_q[6];
    assign sl_config2_o    = active_q[7];
    assign cfg_busy_o      = (state_q == ST_ARMED) | deferred_q;
    assign cfg_applied_o   = applied_q;
    assign cfg_err_o       = err_q;
    assign mute_o          = mute_q;

`ifdef SC_CFG_READBACK_EN
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = active_q[cfg_addr_i];
    end

    always_ff @(posedge PCLK_OUT_i or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign cfg_rdata_o = rdata_q;
`endif

endmodule
